// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;
  localparam int          ITER_CNT  = 32;

  function automatic logic [31:0] mag32(input logic [31:0] x, input logic neg);
    return neg ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// 33-bit adder/subtractor: sum = a + (b ^ sub) + cin, with carry and borrow out.
module muldiv_addsub (
  input  logic [32:0] a_i,
  input  logic [32:0] b_i,
  input  logic        sub_i,
  input  logic        cin_i,
  output logic [32:0] sum_o,
  output logic        cout_o,
  output logic        borrow_o
);

  logic [33:0] full;

  assign full     = {1'b0, a_i} + {1'b0, b_i ^ {33{sub_i}}} + {33'd0, cin_i};
  assign sum_o    = full[32:0];
  assign cout_o   = full[33];
  assign borrow_o = sub_i & ~full[33];

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 RV32M multiply/divide unit feeding the register-file write port.
// state | meaning: IDLE idle | CALC one iteration per clock | FIN sign fix-up | DONE result strobe
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  state_e      state_q, state_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [31:0] result_q, result_d, a_q, a_d, b_q, b_d, spec_res_q, spec_res_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d, rd_q, rd_d;
  logic [2:0]  op_q, op_d;
  logic        sa_q, sa_d, sb_q, sb_d, div0_q, div0_d, spec_q, spec_d;

  logic        in_div, in_sa, in_sb, sign_a, sign_b, in_div0, in_ovf;
  logic [31:0] sel_lo;
  logic [32:0] st_a, st_b, st_sum, hi_sum;
  logic        st_sub, st_cin, st_co, st_borrow, hi_co, hi_borrow;
  logic        unused_bits;

  assign in_div  = funct3[2];
  assign in_sa   = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                   (funct3 == F3_DIV)  || (funct3 == F3_REM);
  assign in_sb   = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
  assign sign_a  = in_sa & src_a[31];
  assign sign_b  = in_sb & src_b[31];
  assign in_div0 = (src_b == 32'd0);
  assign in_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                   (src_a == INT_MIN) && (src_b == DIV0_QUOT);

  // One adder serves the iteration step in CALC and the low-word negation in FIN.
  always_comb begin
    sel_lo = acc_q[31:0];
    if ((op_q == F3_DIV) || (op_q == F3_DIVU))     sel_lo = b_q;
    else if ((op_q == F3_REM) || (op_q == F3_REMU)) sel_lo = acc_q[63:32];
    if (state_q == S_FIN) begin
      st_a = 33'd0;  st_b = {1'b0, sel_lo};  st_sub = 1'b1;  st_cin = 1'b1;
    end else if (op_q[2]) begin
      st_a = {acc_q[63:32], b_q[31]};  st_b = {1'b0, a_q};  st_sub = 1'b1;  st_cin = 1'b1;
    end else begin
      st_a = {1'b0, acc_q[63:32]};  st_b = {1'b0, b_q[0] ? a_q : 32'd0};
      st_sub = 1'b0;  st_cin = 1'b0;
    end
  end

  muldiv_addsub u_step (
    .a_i(st_a), .b_i(st_b), .sub_i(st_sub), .cin_i(st_cin),
    .sum_o(st_sum), .cout_o(st_co), .borrow_o(st_borrow)
  );

  muldiv_addsub u_hi (
    .a_i(33'd0), .b_i({1'b0, acc_q[63:32]}), .sub_i(1'b1), .cin_i(st_co),
    .sum_o(hi_sum), .cout_o(hi_co), .borrow_o(hi_borrow)
  );

  assign unused_bits = ^{hi_sum[32], hi_co, hi_borrow};

  always_comb begin
    state_d = state_q;  result_d = result_q;  a_d = a_q;  b_d = b_q;
    acc_d = acc_q;  cnt_d = cnt_q;  rd_d = rd_q;  op_d = op_q;
    sa_d = sa_q;  sb_d = sb_q;  div0_d = div0_q;  spec_d = spec_q;  spec_res_d = spec_res_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d = S_CALC;
          op_d    = funct3;
          rd_d    = rd_in;
          sa_d    = sign_a;
          sb_d    = sign_b;
          acc_d   = 64'd0;
          cnt_d   = 5'd0;
          div0_d  = in_div & in_div0;
          a_d     = in_div ? mag32(src_b, sign_b) : mag32(src_a, sign_a);
          b_d     = in_div ? mag32(src_a, sign_a) : mag32(src_b, sign_b);
          spec_d  = FAST_SPECIAL && in_div && (in_div0 || in_ovf);
          if (in_div0) spec_res_d = funct3[1] ? src_a : DIV0_QUOT;
          else         spec_res_d = funct3[1] ? 32'd0 : INT_MIN;
        end
      end
      S_CALC: begin
        if (spec_q) begin
          result_d = spec_res_q;
          spec_d   = 1'b0;
          state_d  = S_DONE;
        end else begin
          if (op_q[2]) begin
            // Restoring step: keep the shifted remainder when the trial subtract borrows.
            acc_d = {(st_borrow ? st_a[31:0] : st_sum[31:0]), 32'd0};
            b_d   = {b_q[30:0], ~st_borrow};
          end else begin
            acc_d = {st_sum, acc_q[31:1]};
            b_d   = {1'b0, b_q[31:1]};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(ITER_CNT - 1)) state_d = S_FIN;
        end
      end
      S_FIN: begin
        case (op_q)
          F3_MUL:                     result_d = acc_q[31:0];
          F3_MULH, F3_MULHSU, F3_MULHU: result_d = (sa_q ^ sb_q) ? hi_sum[31:0] : acc_q[63:32];
          // A zero divisor keeps the all-ones quotient regardless of dividend sign.
          F3_DIV, F3_DIVU:            result_d = ((sa_q ^ sb_q) && !div0_q) ? st_sum[31:0] : b_q;
          default:                    result_d = sa_q ? st_sum[31:0] : acc_q[63:32];
        endcase
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_CALC) || (state_d == S_FIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;  busy_q <= 1'b0;  done_q <= 1'b0;  result_q <= 32'd0;
      a_q <= 32'd0;  b_q <= 32'd0;  acc_q <= 64'd0;  cnt_q <= 5'd0;  rd_q <= 5'd0;
      op_q <= 3'd0;  sa_q <= 1'b0;  sb_q <= 1'b0;  div0_q <= 1'b0;
      spec_q <= 1'b0;  spec_res_q <= 32'd0;
    end else begin
      state_q <= state_d;  busy_q <= busy_d;  done_q <= done_d;  result_q <= result_d;
      a_q <= a_d;  b_q <= b_d;  acc_q <= acc_d;  cnt_q <= cnt_d;  rd_q <= rd_d;
      op_q <= op_d;  sa_q <= sa_d;  sb_q <= sb_d;  div0_q <= div0_d;
      spec_q <= spec_d;  spec_res_q <= spec_res_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit. It sits directly downstream of the register file: it consumes the two read-port operands (rd1/rd2) and produces a result, destination index and one-cycle write strobe for the register-file write port (wd3/a3/we3).
- It asserts busy so the core stalls the PC and instruction fetch while an operation is in flight.
- Radix-2 design: one iteration per clock, with a single-cycle shortcut for RISC-V divide special cases.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- FAST_SPECIAL, 1, when 1 divide-by-zero and signed-overflow complete in one cycle; when 0 they use the normal iterative path and must give identical results.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  request; sampled only in IDLE or DONE
- funct3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- src_a  in  32  operand rs1 (register-file rd1)
- src_b  in  32  operand rs2 (register-file rd2)
- rd_in  in  5  destination register index
- busy  out  1  operation in flight; core must stall
- done  out  1  one-cycle result strobe; drives register-file we3
- result  out  32  result; drives wd3, valid while done=1
- rd_out  out  5  destination index captured at start; drives a3

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, result, rd_out and all internal registers go to 0. An in-flight operation is discarded with no done pulse.
- States: IDLE, CALC, FIN, DONE.
- Outputs by state: busy=1 in CALC and FIN only; done=1 in DONE only.
- Accepting start (edge E0, start=1 in IDLE or DONE):
  - Capture funct3 and rd_in.
  - Record the operand signs for signed ops: MULH both, MULHSU src_a only, DIV/REM both.
  - Load operand magnitudes. Clear the 64-bit accumulator and the 5-bit counter.
  - Next state is CALC.
- start while busy=1 is ignored and the operands are not sampled.
- CALC, edges E1..E32: one iteration per edge.
  - Multiply: shift-add on the multiplier LSB.
  - Divide: restoring; shift the remainder left, trial-subtract the divisor, set the quotient bit on no borrow.
  - Counter wraps 31->0 at E32; the state moves to FIN.
- FIN, E33: sign fix-up and result select, then register result and go to DONE.
  - MUL: low 32 bits of the product.
  - MULH/MULHSU/MULHU: high 32 bits. The 64-bit product is negated first when the signs differ.
  - DIV/DIVU: quotient, negated when the signs differ (signed only).
  - REM/REMU: remainder, carrying the sign of the dividend (signed only).
- DONE, E33..E34: done=1 for exactly one cycle. At E34 go to IDLE, or to CALC if start=1 (back-to-back accepted, new operands loaded).
- Normal latency: done visible in the cycle after E33; 34 cycles from start to next accept.
- Special cases (FAST_SPECIAL=1), detected at E0 for div/rem ops, which go straight to DONE at E1:
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give src_a.
  - DIV with 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM gives 0.
- Multiplications never take the shortcut.
- rd_in=0 completes normally with a done pulse; the write is discarded by the register file.
- result holds its value after done falls until the next FIN/special completion.

Decomposition:
- Shared package muldiv_pkg:
  - funct3 encodings for the eight ops.
  - State encoding: 2-bit IDLE=0, CALC=1, FIN=2, DONE=3.
  - Constants DIV0_QUOT=0xFFFFFFFF and INT_MIN=0x80000000.
  - ITER_CNT=32.
- Sub-module muldiv_addsub: 33-bit adder/subtractor with borrow out. It is shared by the multiply add step and the divide trial subtract, and used twice for the FIN negations.

Test Plan:
- MUL 7*6, rd_in=5 -> done one cycle after E33, result=42 (0x0000002A), rd_out=5, busy high E1..E33.
- MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 (-7/2) -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIVU 5/0 -> done after E1, result=0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; repeat with FAST_SPECIAL=0 -> same values at E33.
- start pulsed at E10 mid-CALC with different operands -> ignored, original result returned. rst asserted between edges at E10 -> busy/done/result drop to 0 immediately; no done pulse. Fresh MUL 3*3 after release -> 9.
- Back-to-back: start held during DONE with DIV 20/4 after MUL 2*3 -> done pulses with 6, then 5, 34 cycles apart; no cycle with both busy and done high.
